// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM state and event record for the PS/2 scan decoder
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous key-event FIFO; extra pointer MSB separates full from empty
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  ps2_event_t wr_data_i,
    output ps2_event_t rd_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    ps2_event_t    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          wr_en;
    logic          rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign wr_en     = push_i && (!full_o || pop_i);
    assign rd_en     = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 frame deserializer with F0/E0 prefix folding and event FIFO
// Optional macro PS2_PARITY_CHECK_EN: reject frames whose odd parity does not hold.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] scan_code,
    output logic       key_released,
    output logic       extended,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_e    state_q, state_d;
    logic [2:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          brk_pend_q;
    logic          ext_pend_q;
    logic          frame_err_q;
    logic          overflow_q;

    logic          fall;
    logic          data_s;
    logic          timeout;
    logic          par_ok;
    logic          stop_fall;
    logic          good_byte;
    logic          bad_frame;
    logic          push;
    logic          clr_flags;
    logic          frame_err_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    ps2_event_t    head;
    ps2_event_t    new_ev;

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    state_d = data_s ? IDLE : DATA;
                DATA:    state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        par_ok = ^{shift_q, parity_q};
`else
        par_ok = parity_q | 1'b1;
`endif
        stop_fall   = (state_q == STOP) && fall && !timeout;
        good_byte   = stop_fall && data_s && par_ok;
        bad_frame   = stop_fall && !(data_s && par_ok);
        push        = good_byte && (shift_q != PS2_BREAK) && (shift_q != PS2_EXT);
        clr_flags   = bad_frame || timeout || push;
        frame_err_d = ((state_q == IDLE) && fall && data_s) || bad_frame || timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            tmo_q       <= (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
            if (fall) begin
                case (state_q)
                    IDLE:   bit_cnt_q <= '0;
                    DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    PARITY: parity_q <= data_s;
                    default: ;
                endcase
            end
            if (clr_flags) begin
                brk_pend_q <= 1'b0;
                ext_pend_q <= 1'b0;
            end else if (good_byte && shift_q == PS2_BREAK) begin
                brk_pend_q <= 1'b1;
            end else if (good_byte && shift_q == PS2_EXT) begin
                ext_pend_q <= 1'b1;
            end
            frame_err_q <= frame_err_d;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign new_ev = '{extended: ext_pend_q, released: brk_pend_q, code: shift_q};
    assign pop    = ev_valid && ev_ready;

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (new_ev),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign ev_valid     = !fifo_empty;
    assign scan_code    = ev_valid ? head.code : 8'h00;
    assign key_released = ev_valid && head.released;
    assign extended     = ev_valid && head.extended;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - table-driven directed bench for ps2_scan_decoder
module tb_ps2_scan_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] scan_code;
    logic       key_released;
    logic       extended;
    logic       overflow;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    ps2_scan_decoder #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .scan_code    (scan_code),
        .key_released (key_released),
        .extended     (extended),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_seen <= err_seen + 1;
    end

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic [2:0] bad_stop;
        logic [2:0] bad_par;
        bit         exp_ev;
        logic [7:0] code;
        bit         rel;
        bit         ext;
        int         errs;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(posedge clk);
        #1;
        ev_ready = 1'b0;
    endtask

    function automatic logic [7:0] pick(input vec_t v, input int j);
        return (j == 0) ? v.b0 : (j == 1) ? v.b1 : v.b2;
    endfunction

    task automatic expect_event(input string tag, input logic [7:0] code, input bit rel, input bit ext);
        @(negedge clk);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_code"}, 32'(scan_code), 32'(code));
        check({tag, "_rel"}, 32'(key_released), 32'(rel));
        check({tag, "_ext"}, 32'(extended), 32'(ext));
        pop_one();
        @(negedge clk);
        check({tag, "_empty"}, 32'(ev_valid), 32'd0);
    endtask

    initial begin
        int base;
        vecs[0] = '{1, 8'h1C, 8'h00, 8'h00, 3'b000, 3'b000, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
        vecs[1] = '{2, 8'hF0, 8'h1C, 8'h00, 3'b000, 3'b000, 1'b1, 8'h1C, 1'b1, 1'b0, 0};
        vecs[2] = '{3, 8'hE0, 8'hF0, 8'h75, 3'b000, 3'b000, 1'b1, 8'h75, 1'b1, 1'b1, 0};
        vecs[3] = '{1, 8'h1C, 8'h00, 8'h00, 3'b000, 3'b000, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
        vecs[4] = '{2, 8'hE0, 8'h6B, 8'h00, 3'b000, 3'b000, 1'b1, 8'h6B, 1'b0, 1'b1, 0};
        vecs[5] = '{1, 8'hE1, 8'h00, 8'h00, 3'b000, 3'b000, 1'b1, 8'hE1, 1'b0, 1'b0, 0};
        vecs[6] = '{1, 8'h1C, 8'h00, 8'h00, 3'b001, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1};
        if (PAR_EN)
            vecs[7] = '{2, 8'hF0, 8'h1C, 8'h00, 3'b000, 3'b010, 1'b0, 8'h00, 1'b0, 1'b0, 1};
        else
            vecs[7] = '{2, 8'hF0, 8'h1C, 8'h00, 3'b000, 3'b010, 1'b1, 8'h1C, 1'b1, 1'b0, 0};
        vecs[8] = '{1, 8'h1C, 8'h00, 8'h00, 3'b000, 3'b000, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
        vecs[9] = '{2, 8'hF0, 8'h2A, 8'h00, 3'b001, 3'b000, 1'b1, 8'h2A, 1'b0, 1'b0, 1};

        rst = 1'b1; ev_ready = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        cyc(4);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_code", 32'(scan_code), 32'd0);
        check("rst_rel", 32'(key_released), 32'd0);
        check("rst_ext", 32'(extended), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);

        for (int v = 0; v < 10; v++) begin
            base = err_seen;
            for (int j = 0; j < vecs[v].n; j++)
                send_frame(pick(vecs[v], j), vecs[v].bad_par[j], vecs[v].bad_stop[j]);
            cyc(6);
            if (vecs[v].exp_ev) begin
                expect_event($sformatf("vec%0d", v), vecs[v].code, vecs[v].rel, vecs[v].ext);
            end else begin
                @(negedge clk);
                check($sformatf("vec%0d_noev", v), 32'(ev_valid), 32'd0);
                check($sformatf("vec%0d_gated", v), 32'(scan_code), 32'd0);
            end
            check($sformatf("vec%0d_errs", v), 32'(err_seen - base), 32'(vecs[v].errs));
        end

        // start bit sampled high in IDLE
        base = err_seen;
        send_bit(1'b1);
        ps2_data = 1'b1;
        cyc(10);
        @(negedge clk);
        check("start_err", 32'(err_seen - base), 32'd1);
        check("start_noev", 32'(ev_valid), 32'd0);

        // timeout mid-frame drops the pending break prefix
        send_frame(8'hF0, 1'b0, 1'b0);
        base = err_seen;
        send_partial(8'h5A, 4);
        cyc(TMO + 60);
        @(negedge clk);
        check("tmo_err", 32'(err_seen - base), 32'd1);
        check("tmo_noev", 32'(ev_valid), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        cyc(6);
        expect_event("tmo_after", 8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        cyc(6);
        expect_event("tmo_brk", 8'h1C, 1'b1, 1'b0);

        // overflow: nine makes into an eight-deep FIFO
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        cyc(6);
        @(negedge clk);
        check("ovf_before", 32'(overflow), 32'd0);
        send_frame(8'h09, 1'b0, 1'b0);
        cyc(6);
        @(negedge clk);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(ev_valid), 32'd1);
            check($sformatf("drain%0d_code", i), 32'(scan_code), 32'(i));
            pop_one();
            @(negedge clk);
        end
        check("drain_empty", 32'(ev_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // reset mid-frame with queued events and a pending break prefix
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_partial(8'h33, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 32'(ev_valid), 32'd0);
        check("mrst_code", 32'(scan_code), 32'd0);
        check("mrst_rel", 32'(key_released), 32'd0);
        check("mrst_ext", 32'(extended), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        check("mrst_err", 32'(frame_err), 32'd0);
        cyc(HALF);
        send_frame(8'h1C, 1'b0, 1'b0);
        cyc(6);
        expect_event("mrst_after", 8'h1C, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
